// File: rtl/traffic_pkg.sv
// Shared types, lamp codes and helper functions for the actuated phase controller.
package traffic_pkg;

    localparam int MAX_PHASES = 32;

    typedef enum logic [2:0] {
        ALL_RED, GREEN_WALK, GREEN_FDW, GREEN, YELLOW, FLASH
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_DARK   = 3'b000;

    localparam logic [1:0] WALK      = 2'b01;
    localparam logic [1:0] DONT_WALK = 2'b10;
    localparam logic [1:0] FDW       = 2'b11;
    localparam logic [1:0] WALK_DARK = 2'b00;

    function automatic logic is_green(input state_t s);
        return (s == GREEN_WALK) || (s == GREEN_FDW) || (s == GREEN);
    endfunction

    // First requesting phase after cur (wrapping, cur itself last); 0 when idle.
    function automatic int next_phase(input logic [MAX_PHASES-1:0] req, input int cur, input int n);
        int  idx;
        bit  found;
        next_phase = 0;
        found      = 1'b0;
        for (int k = 1; k <= MAX_PHASES; k++) begin
            if (k <= n) begin
                idx = cur + k;
                if (idx >= n) idx = idx - n;
                if (!found && req[idx[$clog2(MAX_PHASES)-1:0]]) begin
                    next_phase = idx;
                    found      = 1'b1;
                end
            end
        end
    endfunction

    function automatic bit params_ok(input int n, tick_div, timer_w, t_allred, t_min,
                                     t_max, t_yel, t_walk, t_fdw);
        int lim;
        lim = (timer_w >= 31) ? 32'h7fff_ffff : (1 << timer_w);
        return n >= 2 && n <= MAX_PHASES && tick_div >= 1 && timer_w >= 1
            && t_allred >= 1 && t_yel >= 1 && t_walk >= 1 && t_fdw >= 1
            && t_min >= t_walk + t_fdw && t_max >= t_min
            && t_allred < lim && t_max < lim && t_yel < lim;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle timing tick every TICK_DIV cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || tick) cnt <= '0;
        else             cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// N-phase actuated signal controller: round-robin demand service, green extension,
// pedestrian walk/FDW, all-red clearance and night flash. All lamp outputs registered.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int N_PHASES    = 4,
    parameter int TICK_DIV    = 10,
    parameter int TIMER_W     = 8,
    parameter int T_ALLRED    = 2,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_WALK      = 4,
    parameter int T_FDW       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PHASES-1:0]         veh_det,
    input  logic [N_PHASES-1:0]         ped_btn,
    input  logic                        flash_mode,
    output logic [3*N_PHASES-1:0]       veh_light,
    output logic [2*N_PHASES-1:0]       walk_light,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic                        in_flash
);
    localparam int PW = $clog2(N_PHASES);
    localparam logic [TIMER_W-1:0] ALLRED_END = TIMER_W'(T_ALLRED - 1);
    localparam logic [TIMER_W-1:0] YEL_END    = TIMER_W'(T_YELLOW - 1);
    localparam logic [TIMER_W-1:0] WALK_END   = TIMER_W'(T_WALK - 1);
    localparam logic [TIMER_W-1:0] FDW_END    = TIMER_W'(T_FDW - 1);
    localparam logic [TIMER_W-1:0] GMIN       = TIMER_W'(T_MIN_GREEN);
    localparam logic [TIMER_W-1:0] GMAX       = TIMER_W'(T_MAX_GREEN);

    if (!params_ok(N_PHASES, TICK_DIV, TIMER_W, T_ALLRED, T_MIN_GREEN, T_MAX_GREEN,
                   T_YELLOW, T_WALK, T_FDW)) begin : g_bad_params
        $error("traffic_phase_controller: illegal parameter set");
    end

    logic                          tick;
    state_t                        state, nxt_state;
    logic [PW-1:0]                 nxt_phase, rr_phase;
    logic [TIMER_W-1:0]            timer, nxt_timer, gcnt, nxt_gcnt, elapsed;
    logic                          blink, nxt_blink, force0, nxt_force0, enter_green, conflict;
    logic [N_PHASES-1:0]           veh_req, ped_req, cur_sel, nxt_sel;
    logic [N_PHASES-1:0]           green_mask, walk_mask, veh_clr, ped_clr;
    logic [N_PHASES-1:0][2:0]      veh_nxt;
    logic [N_PHASES-1:0][1:0]      walk_nxt;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign cur_sel  = N_PHASES'(1) << active_phase;
    assign nxt_sel  = N_PHASES'(1) << nxt_phase;
    assign elapsed  = (gcnt == GMAX) ? gcnt : gcnt + 1'b1;
    assign conflict = flash_mode || (|((veh_req | ped_req) & ~cur_sel));
    assign rr_phase = PW'(next_phase(MAX_PHASES'(veh_req | ped_req), int'(active_phase), N_PHASES));

    always_comb begin
        nxt_state   = state;
        nxt_phase   = active_phase;
        nxt_timer   = timer;
        nxt_gcnt    = gcnt;
        nxt_blink   = blink;
        nxt_force0  = force0;
        enter_green = 1'b0;
        if (tick) begin
            nxt_timer = timer + 1'b1;
            if (is_green(state)) nxt_gcnt = elapsed;
            case (state)
                ALL_RED: if (timer == ALLRED_END) begin
                    nxt_timer = '0;
                    if (flash_mode) begin
                        nxt_state = FLASH;
                        nxt_blink = 1'b1;
                    end else begin
                        nxt_phase   = force0 ? '0 : rr_phase;
                        nxt_force0  = 1'b0;
                        nxt_gcnt    = '0;
                        enter_green = 1'b1;
                        nxt_state   = ped_req[nxt_phase] ? GREEN_WALK : GREEN;
                    end
                end
                GREEN_WALK: if (timer == WALK_END) begin
                    nxt_state = GREEN_FDW;
                    nxt_timer = '0;
                end
                GREEN_FDW: if (timer == FDW_END) begin
                    nxt_state = GREEN;
                    nxt_timer = '0;
                end
                // Gap-out or max-out, only once minimum green has run and someone else waits.
                GREEN: if (elapsed >= GMIN && conflict &&
                           (!veh_det[active_phase] || elapsed == GMAX)) begin
                    nxt_state = YELLOW;
                    nxt_timer = '0;
                end
                YELLOW: if (timer == YEL_END) begin
                    nxt_state = ALL_RED;
                    nxt_timer = '0;
                end
                FLASH: if (!flash_mode) begin
                    nxt_state  = ALL_RED;
                    nxt_timer  = '0;
                    nxt_force0 = 1'b1;
                end else begin
                    nxt_blink = ~blink;
                end
                default: nxt_state = ALL_RED;
            endcase
        end
    end

    assign green_mask = is_green(state) ? cur_sel : '0;
    assign walk_mask  = (state == GREEN_WALK) ? cur_sel : '0;
    assign veh_clr    = enter_green ? nxt_sel : '0;
    assign ped_clr    = (enter_green && nxt_state == GREEN_WALK) ? nxt_sel : '0;

    always_comb begin
        for (int i = 0; i < N_PHASES; i++) begin
            veh_nxt[i]  = LIGHT_RED;
            walk_nxt[i] = DONT_WALK;
            if (nxt_state == FLASH) begin
                walk_nxt[i] = WALK_DARK;
                if (!nxt_blink)  veh_nxt[i] = LIGHT_DARK;
                else if (i == 0) veh_nxt[i] = LIGHT_YELLOW;
            end else if (int'(nxt_phase) == i) begin
                case (nxt_state)
                    GREEN_WALK: begin veh_nxt[i] = LIGHT_GREEN; walk_nxt[i] = WALK; end
                    GREEN_FDW:  begin veh_nxt[i] = LIGHT_GREEN; walk_nxt[i] = FDW;  end
                    GREEN:      veh_nxt[i] = LIGHT_GREEN;
                    YELLOW:     veh_nxt[i] = LIGHT_YELLOW;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ALL_RED;
            active_phase <= '0;
            timer        <= '0;
            gcnt         <= '0;
            blink        <= 1'b0;
            force0       <= 1'b1;
            veh_req      <= '0;
            ped_req      <= '0;
            veh_light    <= {N_PHASES{LIGHT_RED}};
            walk_light   <= {N_PHASES{DONT_WALK}};
            in_flash     <= 1'b0;
        end else begin
            state        <= nxt_state;
            active_phase <= nxt_phase;
            timer        <= nxt_timer;
            gcnt         <= nxt_gcnt;
            blink        <= nxt_blink;
            force0       <= nxt_force0;
            veh_req      <= (veh_req | (veh_det & ~green_mask)) & ~veh_clr;
            ped_req      <= (ped_req | (ped_btn & ~walk_mask)) & ~ped_clr;
            veh_light    <= veh_nxt;
            walk_light   <= walk_nxt;
            in_flash     <= (nxt_state == FLASH);
        end
    end

endmodule
